snake_body_engine: RTL
======================

# snake_body_engine

Parametrised snake body store and movement engine for the Snake game. Holds up to MAX_LEN grid positions, advances the head one cell per game-clock tick in the navigated direction, grows on reaching the target and detects self-collision with a serial body scan. It also serves as the VGA pixel occupancy lookup. Sits between the navigation state machine and game-speed counter upstream, and the master state machine, score counter and VGA wrapper downstream.

## Interface
- H_WIDTH, 8: grid X coordinate width
- V_WIDTH, 7: grid Y coordinate width
- GRID_X_MAX, 159 / GRID_Y_MAX, 119: last valid column / row
- MAX_LEN, 32: body capacity in segments (2..256)
- INIT_LEN, 4: length after reset/INIT (2..MAX_LEN)
- START_X, 20 / START_Y, 15: initial head cell; segment i at (START_X-i, START_Y)
- WRAP, 0: 1 = wrap at walls, 0 = wall is fatal
- CLK  in  1  system clock; the only clock
- RESET  in  1  asynchronous, active-low reset
- GAMECLOCK  in  1  one-cycle move tick
- PLAY  in  1  master state is "play"; ticks ignored when low
- INIT  in  1  one-cycle pulse: synchronous reinitialise of body
- NAV_STATE  in  2  requested direction: 0 up, 1 right, 2 down, 3 left
- TARGET_X / TARGET_Y  in  H_WIDTH / V_WIDTH  current target cell
- QUERY_X / QUERY_Y  in  H_WIDTH / V_WIDTH  cell under VGA scan
- QUERY_HIT  out  1  registered: query cell occupied by body
- HEAD_X / HEAD_Y  out  H_WIDTH / V_WIDTH  current head
- LENGTH  out  $clog2(MAX_LEN+1)  current segment count
- REACHED_TARGET  out  1  one-cycle pulse on eating target
- SUICIDE  out  1  sticky: collision with self or wall
- BUSY  out  1  step/scan in progress

## Operation
- Reset/INIT: segments at start positions, heading right, LENGTH=INIT_LEN, state IDLE; REACHED_TARGET=0, SUICIDE=0, BUSY=0, QUERY_HIT=0. INIT overrides everything else in the same cycle, including mid-scan.
- States: IDLE, STEP, SCAN, DEAD.
- IDLE: GAMECLOCK & PLAY -> STEP. Tick with PLAY low: ignored.
- STEP (1 cycle): latch heading from NAV_STATE unless it is the exact reverse of current heading (then keep). Compute next head (y-1 up, x+1 right, y+1 down, x-1 left). WRAP=1: wrap modulo GRID_*_MAX+1. WRAP=0 and leaving grid: no move, SUICIDE=1, -> DEAD. Else shift seg[i]<=seg[i-1], seg[0]<=next. If next == target: LENGTH+=1 saturating at MAX_LEN (new tail = old tail, kept), REACHED_TARGET pulse. -> SCAN.
- SCAN: index k runs 1..LENGTH-1, one compare per cycle against seg[0]; any match -> SUICIDE=1, DEAD. End with no match -> IDLE.
- DEAD: ignores ticks; leaves only on INIT or RESET.
- GAMECLOCK arriving while BUSY: dropped, no queuing.
- QUERY_HIT: parallel compare of query against seg[0..LENGTH-1], registered.

## Timing
- Tick sampled at cycle t -> STEP at t+1; HEAD_X/Y, LENGTH, REACHED_TARGET visible t+2.
- SCAN occupies t+2 .. t+LENGTH; SUICIDE (self) visible t+LENGTH+1; wall SUICIDE visible t+2.
- BUSY high from t+1 through last SCAN cycle.
- Required tick spacing >= MAX_LEN+2 cycles (game clock far exceeds this).
- QUERY_HIT latency 1 cycle from QUERY_X/Y.

## Structure
- Package snake_pkg: direction enum (UP, RIGHT, DOWN, LEFT), engine state enum, reverse-direction function.
- Sub-module snake_next_head: combinational next-cell and wall-exit computation, parameterised by widths, grid limits and WRAP.

## Test plan
- Reset: RESET low then high -> HEAD=(20,15), LENGTH=4, all flags 0; QUERY (17,15) hit, (16,15) miss.
- Three ticks, NAV=right, PLAY=1 -> HEAD=(23,15), LENGTH=4, tail at (20,15).
- Target at (21,15), one tick -> REACHED_TARGET one cycle at t+2, LENGTH=5; ten ticks at MAX_LEN=5 -> LENGTH stays 5.
- NAV=left while heading right -> heading unchanged, HEAD x+1.
- LENGTH=5, sequence up, left, down -> SUICIDE at t+LENGTH+1, further ticks ignored, INIT restores reset state.
- Head at (159,15) heading right: WRAP=1 -> HEAD=(0,15); WRAP=0 -> SUICIDE at t+2, HEAD unchanged; INIT mid-SCAN -> reset state next cycle.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake body engine: directions, engine states
// and the reverse-direction helper.
package snake_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      RIGHT = 2'd1,
      DOWN  = 2'd2,
      LEFT  = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      IDLE,
      STEP,
      SCAN,
      DEAD
   } eng_state_e;

   // Opposite directions differ only in the upper encoding bit.
   function automatic dir_e rev_dir(dir_e d);
      return dir_e'(d ^ 2'b10);
   endfunction

endpackage

// File: rtl/snake_body_engine_if.sv
// VGA occupancy lookup bus: the scan position goes in, the registered
// body-hit flag comes back.
interface snake_body_engine_if #(
   parameter int H_WIDTH = 8,
   parameter int V_WIDTH = 7
);
   logic [H_WIDTH-1:0] QUERY_X;
   logic [V_WIDTH-1:0] QUERY_Y;
   logic               QUERY_HIT;

   modport master (output QUERY_X, QUERY_Y, input QUERY_HIT);
   modport slave  (input QUERY_X, QUERY_Y, output QUERY_HIT);
endinterface

// File: rtl/snake_next_head.sv
// Next head cell for a given direction, with wall wrap or wall-exit
// detection. On exit the cell is left unchanged.
module snake_next_head
   import snake_pkg::*;
#(
   parameter int H_WIDTH    = 8,
   parameter int V_WIDTH    = 7,
   parameter int GRID_X_MAX = 159,
   parameter int GRID_Y_MAX = 119,
   parameter int WRAP       = 0
) (
   input  logic [H_WIDTH-1:0] x_i,
   input  logic [V_WIDTH-1:0] y_i,
   input  dir_e               dir_i,
   output logic [H_WIDTH-1:0] x_o,
   output logic [V_WIDTH-1:0] y_o,
   output logic               exit_o
);
   localparam logic [H_WIDTH-1:0] XMAX = H_WIDTH'(GRID_X_MAX);
   localparam logic [V_WIDTH-1:0] YMAX = V_WIDTH'(GRID_Y_MAX);

   always_comb begin
      x_o    = x_i;
      y_o    = y_i;
      exit_o = 1'b0;
      unique case (dir_i)
         UP: begin
            if (y_i != '0)        y_o    = y_i - 1'b1;
            else if (WRAP != 0)   y_o    = YMAX;
            else                  exit_o = 1'b1;
         end
         RIGHT: begin
            if (x_i != XMAX)      x_o    = x_i + 1'b1;
            else if (WRAP != 0)   x_o    = '0;
            else                  exit_o = 1'b1;
         end
         DOWN: begin
            if (y_i != YMAX)      y_o    = y_i + 1'b1;
            else if (WRAP != 0)   y_o    = '0;
            else                  exit_o = 1'b1;
         end
         LEFT: begin
            if (x_i != '0)        x_o    = x_i - 1'b1;
            else if (WRAP != 0)   x_o    = XMAX;
            else                  exit_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body store: moves the head per game tick, grows on the target,
// serially scans for self-collision and answers VGA occupancy queries.
module snake_body_engine
   import snake_pkg::*;
#(
   parameter int H_WIDTH    = 8,
   parameter int V_WIDTH    = 7,
   parameter int GRID_X_MAX = 159,
   parameter int GRID_Y_MAX = 119,
   parameter int MAX_LEN    = 32,
   parameter int INIT_LEN   = 4,
   parameter int START_X    = 20,
   parameter int START_Y    = 15,
   parameter int WRAP       = 0
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         GAMECLOCK,
   input  logic                         PLAY,
   input  logic                         INIT,
   input  logic [1:0]                   NAV_STATE,
   input  logic [H_WIDTH-1:0]           TARGET_X,
   input  logic [V_WIDTH-1:0]           TARGET_Y,
   snake_body_engine_if.slave           query,
   output logic [H_WIDTH-1:0]           HEAD_X,
   output logic [V_WIDTH-1:0]           HEAD_Y,
   output logic [$clog2(MAX_LEN+1)-1:0] LENGTH,
   output logic                         REACHED_TARGET,
   output logic                         SUICIDE,
   output logic                         BUSY
);
   localparam int LW = $clog2(MAX_LEN+1);
   localparam int IW = $clog2(MAX_LEN);

   eng_state_e         state_q;
   dir_e               dir_q, dir_d, nav;
   logic [H_WIDTH-1:0] segx_q [MAX_LEN];
   logic [V_WIDTH-1:0] segy_q [MAX_LEN];
   logic [LW-1:0]      len_q;
   logic [IW-1:0]      k_q;
   logic               reached_q, suicide_q, hit_q, hit_d;
   logic [H_WIDTH-1:0] nx;
   logic [V_WIDTH-1:0] ny;
   logic               wall, eat, scan_hit, scan_last;

   assign nav   = dir_e'(NAV_STATE);
   assign dir_d = (nav == rev_dir(dir_q)) ? dir_q : nav;

   snake_next_head #(
      .H_WIDTH(H_WIDTH), .V_WIDTH(V_WIDTH),
      .GRID_X_MAX(GRID_X_MAX), .GRID_Y_MAX(GRID_Y_MAX),
      .WRAP(WRAP)
   ) u_next_head (
      .x_i(segx_q[0]), .y_i(segy_q[0]), .dir_i(dir_d),
      .x_o(nx), .y_o(ny), .exit_o(wall)
   );

   assign eat       = (nx == TARGET_X) && (ny == TARGET_Y);
   assign scan_hit  = (segx_q[k_q] == segx_q[0]) &&
                      (segy_q[k_q] == segy_q[0]);
   assign scan_last = (LW'(k_q) == len_q - 1'b1);

   always_comb begin
      hit_d = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if ((LW'(i) < len_q) &&
             (segx_q[i] == query.QUERY_X) &&
             (segy_q[i] == query.QUERY_Y))
            hit_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= IDLE;
         dir_q     <= RIGHT;
         len_q     <= LW'(INIT_LEN);
         k_q       <= '0;
         reached_q <= 1'b0;
         suicide_q <= 1'b0;
         hit_q     <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) begin
            segx_q[i] <= H_WIDTH'(START_X - i);
            segy_q[i] <= V_WIDTH'(START_Y);
         end
      end else if (INIT) begin
         state_q   <= IDLE;
         dir_q     <= RIGHT;
         len_q     <= LW'(INIT_LEN);
         k_q       <= '0;
         reached_q <= 1'b0;
         suicide_q <= 1'b0;
         hit_q     <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) begin
            segx_q[i] <= H_WIDTH'(START_X - i);
            segy_q[i] <= V_WIDTH'(START_Y);
         end
      end else begin
         reached_q <= 1'b0;
         hit_q     <= hit_d;
         unique case (state_q)
            IDLE: if (GAMECLOCK && PLAY) state_q <= STEP;
            STEP: begin
               dir_q <= dir_d;
               if (wall) begin
                  suicide_q <= 1'b1;
                  state_q   <= DEAD;
               end else begin
                  // At full length the shift drops the oldest tail cell
                  for (int i = MAX_LEN-1; i > 0; i--) begin
                     segx_q[i] <= segx_q[i-1];
                     segy_q[i] <= segy_q[i-1];
                  end
                  segx_q[0] <= nx;
                  segy_q[0] <= ny;
                  if (eat) begin
                     reached_q <= 1'b1;
                     if (len_q != LW'(MAX_LEN)) len_q <= len_q + 1'b1;
                  end
                  k_q     <= IW'(1);
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               if (scan_hit) begin
                  suicide_q <= 1'b1;
                  state_q   <= DEAD;
               end else if (scan_last) begin
                  state_q <= IDLE;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            DEAD: ;
         endcase
      end
   end

   assign HEAD_X          = segx_q[0];
   assign HEAD_Y          = segy_q[0];
   assign LENGTH          = len_q;
   assign REACHED_TARGET  = reached_q;
   assign SUICIDE         = suicide_q;
   assign BUSY            = (state_q == STEP) || (state_q == SCAN);
   assign query.QUERY_HIT = hit_q;

endmodule
